mem_arbiter: RTL

//  Shares one single-port, byte-writable RAM between the core's instruction-fetch port and data port.

---
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, byte-writable RAM between the
// instruction-fetch port and the data port of the core. Data accesses win
// arbitration, but a data streak limit guarantees a waiting fetch gets in.
// Each port sees a combinational stall that holds its pipeline stage until
// the RAM access for that port has completed.
module mem_arbiter #(
   parameter int          ADDR_W          = 32,
   parameter int          MAX_DATA_STREAK = 4,
   parameter logic [31:0] RESET_INSTR     = 32'h00000013
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic [ADDR_W-1:0] IMEM_addr_i,
   input  logic              IMEM_read_n_i,
   output logic [31:0]       IMEM_data_o,
   output logic              IMEM_stall_o,

   input  logic [ADDR_W-1:0] DMEM_addr_i,
   input  logic [31:0]       DMEM_data_i,
   input  logic              DMEM_read_i,
   input  logic [3:0]        DMEM_write_byte_i,
   output logic [31:0]       DMEM_data_o,
   output logic              DMEM_stall_o,

   output logic              RAM_req_o,
   output logic [ADDR_W-1:0] RAM_addr_o,
   output logic [31:0]       RAM_wdata_o,
   output logic [3:0]        RAM_we_o,
   input  logic              RAM_ack_i,
   input  logic [31:0]       RAM_rdata_i
);

   // Streak counter must be able to hold MAX_DATA_STREAK itself.
   localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
   localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      INSTR = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_nextState;

   logic                r_ramReq;
   logic [ADDR_W-1:0]   r_ramAddr;
   logic [31:0]         r_ramWdata;
   logic [3:0]          r_ramWe;
   logic [31:0]         r_imemData;
   logic [31:0]         r_dmemData;
   logic                r_iDone;
   logic                r_dDone;
   logic [STREAK_W-1:0] r_streak;

   logic                w_ireq;
   logic                w_dreq;
   logic                w_eligI;
   logic                w_eligD;
   logic                w_anyDone;
   logic                w_grantD;
   logic                w_grantI;
   logic                w_dataAck;
   logic                w_instrAck;

   // Request decode: a store with a read strobe is still a store because its
   // byte enables are non-zero and get captured as the RAM write enables.
   assign w_ireq    = ~IMEM_read_n_i;
   assign w_dreq    = DMEM_read_i | (|DMEM_write_byte_i);
   assign w_eligI   = w_ireq & ~r_iDone;
   assign w_eligD   = w_dreq & ~r_dDone;
   assign w_anyDone = r_iDone | r_dDone;

   // Acks only mean something while a transfer is outstanding.
   assign w_dataAck  = (r_state == DATA)  & RAM_ack_i;
   assign w_instrAck = (r_state == INSTR) & RAM_ack_i;

   assign IMEM_stall_o = w_ireq & ~r_iDone;
   assign DMEM_stall_o = w_dreq & ~r_dDone;

   assign RAM_req_o   = r_ramReq;
   assign RAM_addr_o  = r_ramAddr;
   assign RAM_wdata_o = r_ramWdata;
   assign RAM_we_o    = r_ramWe;
   assign IMEM_data_o = r_imemData;
   assign DMEM_data_o = r_dmemData;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Arbitration and transfer sequencing. The done cycle is a turnaround
   // cycle: the finished requester advances and nobody is granted, so a
   // back-to-back data stream competes with a waiting fetch on equal footing
   // every access and the streak limit decides who goes next.
   always_comb begin
      w_nextState = r_state;
      w_grantD    = 1'b0;
      w_grantI    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_anyDone) begin
               if (w_eligD && !(w_eligI && (r_streak == STREAK_MAX))) begin
                  w_grantD    = 1'b1;
                  w_nextState = DATA;
               end else if (w_eligI) begin
                  w_grantI    = 1'b1;
                  w_nextState = INSTR;
               end
            end
         end
         DATA: begin
            if (RAM_ack_i) begin
               w_nextState = IDLE;
            end
         end
         INSTR: begin
            if (RAM_ack_i) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // RAM command registers: loaded on a grant, held until the ack edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ramReq   <= 1'b0;
         r_ramAddr  <= '0;
         r_ramWdata <= '0;
         r_ramWe    <= '0;
      end else if (w_grantD) begin
         r_ramReq   <= 1'b1;
         r_ramAddr  <= DMEM_addr_i;
         r_ramWdata <= DMEM_data_i;
         r_ramWe    <= DMEM_write_byte_i;
      end else if (w_grantI) begin
         r_ramReq   <= 1'b1;
         r_ramAddr  <= IMEM_addr_i;
         r_ramWdata <= '0;
         r_ramWe    <= '0;
      end else if (w_dataAck || w_instrAck) begin
         r_ramReq   <= 1'b0;
         r_ramWe    <= '0;
      end
   end

   // Read-data capture; stores leave the load data register untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_imemData <= RESET_INSTR;
         r_dmemData <= '0;
      end else begin
         if (w_instrAck) begin
            r_imemData <= RAM_rdata_i;
         end
         if (w_dataAck && (r_ramWe == 4'b0000)) begin
            r_dmemData <= RAM_rdata_i;
         end
      end
   end

   // One-cycle done pulses that release the stall and block an immediate
   // re-grant of the request the pipeline has not yet advanced past.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_iDone <= 1'b0;
         r_dDone <= 1'b0;
      end else begin
         r_iDone <= w_instrAck;
         r_dDone <= w_dataAck;
      end
   end

   // Data streak: counts data grants made while a fetch is waiting,
   // saturating at the limit; any fetch grant or uncontested data grant
   // starts the count over.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_streak <= '0;
      end else if (w_grantD) begin
         if (w_ireq) begin
            if (r_streak != STREAK_MAX) begin
               r_streak <= r_streak + STREAK_ONE;
            end
         end else begin
            r_streak <= '0;
         end
      end else if (w_grantI) begin
         r_streak <= '0;
      end
   end

endmodule
